// File: rtl/cg_rvarch_ptw_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cg_rvarch_ptw_arb_pkg
// Brief    : Shared types and defaults for the ITLB/DTLB page-table-walk arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cg_rvarch_ptw_arb_pkg;

  localparam int c_TIMEOUT_CYCLES_DFLT = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // Value doubles as the bit index into the two-bit request/grant vectors.
  typedef enum logic {
    REQ_ITLB = 1'b0,
    REQ_DTLB = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/cg_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : cg_rr_arb2
// Brief    : Two-way round-robin arbiter; bit 0 = ITLB, bit 1 = DTLB.
// Revision : 1.0 - initial release
// ============================================================================
module cg_rr_arb2
  import cg_rvarch_ptw_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  req_id_e r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last == REQ_DTLB) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Reset points at ITLB so a contested first grant goes to the DTLB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= REQ_ITLB;
    end else if (i_advance && (|o_grant)) begin
      r_last <= o_grant[1] ? REQ_DTLB : REQ_ITLB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cg_rvarch_ptw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cg_rvarch_ptw_arbiter
// Brief    : Shares one page-table walker between ITLB and DTLB misses.
//            Define CG_PTW_ARB_TIMEOUT_EN to bound the walk wait.
// Revision : 1.0 - initial release
// ============================================================================
module cg_rvarch_ptw_arbiter
  import cg_rvarch_ptw_arb_pkg::*;
#(
  parameter int VADDR_WIDTH    = 39,
  parameter int PADDR_WIDTH    = 56,
  parameter int ATTR_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DFLT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_itlb_miss,
  input  logic [VADDR_WIDTH-1:0] i_itlb_vaddr,
  output logic                   o_itlb_valid,
  output logic                   o_itlb_fault,
  output logic [PADDR_WIDTH-1:0] o_itlb_paddr,
  output logic [ATTR_WIDTH-1:0]  o_itlb_attr,
  input  logic                   i_dtlb_miss,
  input  logic [VADDR_WIDTH-1:0] i_dtlb_vaddr,
  output logic                   o_dtlb_valid,
  output logic                   o_dtlb_fault,
  output logic [PADDR_WIDTH-1:0] o_dtlb_paddr,
  output logic [ATTR_WIDTH-1:0]  o_dtlb_attr,
  output logic                   o_ptw_miss,
  output logic [VADDR_WIDTH-1:0] o_ptw_vaddr,
  input  logic                   i_ptw_valid,
  input  logic                   i_ptw_fault,
  input  logic [PADDR_WIDTH-1:0] i_ptw_paddr,
  input  logic [ATTR_WIDTH-1:0]  i_ptw_attr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                 r_state;
  state_e                 w_state_nxt;
  req_id_e                r_gnt;
  req_id_e                w_gnt_id;
  logic                   r_valid;
  logic                   r_fault;
  logic                   r_to_drain;
  logic [1:0]             w_req;
  logic [1:0]             w_grant;
  logic                   w_ptw_rsp;
  logic                   w_start;
  logic                   w_timeout;
  logic                   w_resp;
  logic [VADDR_WIDTH-1:0] r_ptw_vaddr;
  logic [PADDR_WIDTH-1:0] r_itlb_paddr;
  logic [PADDR_WIDTH-1:0] r_dtlb_paddr;
  logic [ATTR_WIDTH-1:0]  r_itlb_attr;
  logic [ATTR_WIDTH-1:0]  r_dtlb_attr;

  assign w_req     = {i_dtlb_miss, i_itlb_miss};
  assign w_ptw_rsp = i_ptw_valid | i_ptw_fault;
  assign w_start   = (r_state == IDLE) && (|w_req) && !i_flush;
  assign w_gnt_id  = w_grant[1] ? REQ_DTLB : REQ_ITLB;

  cg_rr_arb2 u_rr_arb2 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (w_req),
    .i_advance (w_start),
    .o_grant   (w_grant)
  );

`ifdef CG_PTW_ARB_TIMEOUT_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_wait_cnt;

  // Holds the number of WAIT cycles already spent; zero on the first one.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != WAIT)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
    end
  end

  assign w_timeout = (r_state == WAIT) && (r_wait_cnt == c_CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_resp       = (r_state == RESP);
    o_ptw_miss   = (r_state == ISSUE);
    o_itlb_valid = w_resp && (r_gnt == REQ_ITLB) && r_valid;
    o_itlb_fault = w_resp && (r_gnt == REQ_ITLB) && r_fault;
    o_dtlb_valid = w_resp && (r_gnt == REQ_DTLB) && r_valid;
    o_dtlb_fault = w_resp && (r_gnt == REQ_DTLB) && r_fault;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = ISSUE;
      end
      ISSUE, WAIT: begin
        // A flushed walk is still in flight unless its response lands now.
        if (i_flush) begin
          w_state_nxt = w_ptw_rsp ? IDLE : DRAIN;
        end else if (r_state == ISSUE) begin
          w_state_nxt = WAIT;
        end else if (w_ptw_rsp || w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = (r_to_drain && !w_ptw_rsp) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (w_ptw_rsp) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt        <= REQ_ITLB;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_to_drain   <= 1'b0;
      r_ptw_vaddr  <= '0;
      r_itlb_paddr <= '0;
      r_dtlb_paddr <= '0;
      r_itlb_attr  <= '0;
      r_dtlb_attr  <= '0;
    end else begin
      if (w_start) begin
        r_gnt       <= w_gnt_id;
        r_ptw_vaddr <= w_grant[1] ? i_dtlb_vaddr : i_itlb_vaddr;
      end
      if ((r_state == WAIT) && !i_flush) begin
        if (w_ptw_rsp) begin
          r_valid    <= ~i_ptw_fault;
          r_fault    <= i_ptw_fault;
          r_to_drain <= 1'b0;
          if (r_gnt == REQ_DTLB) begin
            r_dtlb_paddr <= i_ptw_paddr;
            r_dtlb_attr  <= i_ptw_attr;
          end else begin
            r_itlb_paddr <= i_ptw_paddr;
            r_itlb_attr  <= i_ptw_attr;
          end
        end else if (w_timeout) begin
          r_valid    <= 1'b0;
          r_fault    <= 1'b1;
          r_to_drain <= 1'b1;
        end
      end
    end
  end

  assign o_ptw_vaddr  = r_ptw_vaddr;
  assign o_itlb_paddr = r_itlb_paddr;
  assign o_itlb_attr  = r_itlb_attr;
  assign o_dtlb_paddr = r_dtlb_paddr;
  assign o_dtlb_attr  = r_dtlb_attr;

endmodule
`default_nettype wire

// File: doc/cg_rvarch_ptw_arbiter.md
CG_RVARCH_PTW_ARBITER -- requirements
Module: cg_rvarch_ptw_arbiter

Interface
REQ-001 Parameters SHALL be: VADDR_WIDTH, default 39, virtual address width; PADDR_WIDTH, default 56, physical address width; ATTR_WIDTH, default 11, PTE attribute width; TIMEOUT_CYCLES, default 255, walk timeout in cycles.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk  in  1  clock, all logic on its rising edge
- i_rst  in  1  synchronous active-high reset
- i_flush  in  1  abort the current walk and discard its result
- i_itlb_miss  in  1  ITLB walk request; level signal, held until response
- i_itlb_vaddr  in  VADDR_WIDTH  ITLB miss address
- o_itlb_valid  out  1  one-cycle pulse: ITLB translation ready
- o_itlb_fault  out  1  one-cycle pulse: ITLB page fault
- o_itlb_paddr  out  PADDR_WIDTH  ITLB result physical address
- o_itlb_attr  out  ATTR_WIDTH  ITLB result attributes
- i_dtlb_miss, i_dtlb_vaddr, o_dtlb_valid, o_dtlb_fault, o_dtlb_paddr, o_dtlb_attr: same as the ITLB ports, for the DTLB
- o_ptw_miss  out  1  one-cycle walk-start pulse to the PTW
- o_ptw_vaddr  out  VADDR_WIDTH  walk address, stable from the start pulse until the PTW responds
- i_ptw_valid  in  1  PTW translation complete
- i_ptw_fault  in  1  PTW page fault
- i_ptw_paddr  in  PADDR_WIDTH  PTW physical address
- i_ptw_attr  in  ATTR_WIDTH  PTW attributes

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP and DRAIN.
REQ-005 IDLE: if any miss is asserted and i_flush=0, the block SHALL latch the granted ID and its vaddr into o_ptw_vaddr and go to ISSUE. Otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin:
- only one miss asserted: that requester wins;
- both asserted: the requester not granted last wins;
- after reset, DTLB has priority.
REQ-007 ISSUE SHALL assert o_ptw_miss for exactly one cycle and then go to WAIT.
REQ-008 WAIT: on i_ptw_valid or i_ptw_fault, the block SHALL register paddr, attr, valid and fault for the granted requester and go to RESP.
REQ-009 RESP SHALL drive the granted requester's valid or fault for one cycle, then go to IDLE. The non-granted requester's valid and fault SHALL stay 0.
REQ-010 Requesters SHALL deassert miss in the RESP cycle. The arbiter SHALL NOT re-sample miss until IDLE.
REQ-011 The latched vaddr and grant SHALL be immune to miss or vaddr changes after the grant.
REQ-012 Flush:
- i_flush in ISSUE or WAIT with no PTW response that cycle: go to DRAIN, with no requester response.
- Flush coincident with a PTW response: discard the response and go to IDLE.
- Flush in RESP: the response is still delivered.
REQ-013 DRAIN SHALL wait for i_ptw_valid or i_ptw_fault, discard it, and go to IDLE. The PTW SHALL NOT be issued a new walk before then.
REQ-014 The paddr and attr outputs SHALL hold their last registered value outside RESP.
REQ-015 If i_ptw_valid and i_ptw_fault are both asserted, the fault SHALL take precedence.

Reset
REQ-016 While i_rst=1 at a clock edge:
- state SHALL go to IDLE;
- all valid, fault and o_ptw_miss outputs SHALL be 0;
- the last-grant pointer SHALL be set to ITLB, so that DTLB wins first;
- the timeout counter SHALL be 0;
- paddr, attr and vaddr outputs SHALL be 0.
REQ-017 Reset mid-walk SHALL abandon the walk with no response. The PTW SHALL be reset by the same reset.

Configuration
REQ-018 With CG_PTW_ARB_TIMEOUT_EN defined:
- a counter SHALL clear on WAIT entry and increment each WAIT cycle;
- on reaching TIMEOUT_CYCLES without a PTW response, the block SHALL pulse the requester's fault in RESP and then go to DRAIN instead of IDLE;
- a PTW response coincident with the timeout SHALL win.
REQ-019 Without CG_PTW_ARB_TIMEOUT_EN, there SHALL be no counter and WAIT SHALL be unbounded.

Structure
REQ-020 Package cg_rvarch_ptw_arb_pkg SHALL hold the state enum, the requester ID enum {REQ_ITLB, REQ_DTLB}, and the TIMEOUT_CYCLES default.
REQ-021 The two-way round-robin choice SHALL be the sub-module cg_rr_arb2 (req[1:0], advance, grant[1:0]).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single DTLB miss, vaddr 0x40_0000_1000, PTW valid with paddr 0x8000_2000 in the 5th WAIT cycle -> one o_ptw_miss pulse, o_dtlb_valid 1 cycle with paddr 0x8000_2000, o_itlb_* stays 0.
- ITLB and DTLB misses in the same cycle after reset -> DTLB served first, then ITLB; on the next simultaneous pair, ITLB first.
- PTW fault on an ITLB walk -> o_itlb_fault 1 cycle, o_itlb_valid 0.
- i_flush in the 2nd WAIT cycle, PTW responds 3 cycles later -> no requester response, next o_ptw_miss only after the response.
- Flush coincident with i_ptw_valid -> response discarded, IDLE next cycle.
- With CG_PTW_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, PTW silent -> requester fault after 8 WAIT cycles, then DRAIN until the PTW responds.
